// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the RX/TX paths
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  localparam int OSR_DEFAULT       = 16;
  localparam int DATA_BITS_MIN     = 5;
  localparam int DATA_BITS_MAX     = 9;
  localparam int DATA_BITS_DEFAULT = 8;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-byte valid/ready channel with error flags
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - OSR-tick down-counter with load and zero strobe
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int            W      = idx_width(OSR);
  localparam logic [W-1:0]  RELOAD = W'(OSR - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

  // Load wins over a coincident enable, so a fresh start never strobes.
  assign zero = en && !load && (cnt == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART RX deserialiser: samples data/stop bits, delivers byte on valid/ready
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OSR       = OSR_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_rx,
  input  logic             i_found,
  output logic             o_busy,
  uart_rx_frame_if.master  rx_out
);

  localparam int             BW       = idx_width(DATA_BITS);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 start;
  logic                 timer_en;
  logic                 tick;

  assign start    = (state == ST_IDLE) && i_found;
  assign timer_en = i_en && (state != ST_IDLE);
  assign o_busy   = (state != ST_IDLE);

  uart_bit_timer #(
    .OSR (OSR)
  ) u_timer (
    .clk   (i_clk),
    .rst_n (i_rst),
    .load  (start),
    .en    (timer_en),
    .zero  (tick)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state              <= ST_IDLE;
      bit_idx            <= '0;
      shreg              <= '0;
      rx_out.o_data      <= '0;
      rx_out.o_valid     <= 1'b0;
      rx_out.o_frame_err <= 1'b0;
      rx_out.o_overrun   <= 1'b0;
    end else begin
      rx_out.o_overrun <= 1'b0;
      if (rx_out.o_valid && rx_out.i_ready) begin
        rx_out.o_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (i_found) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (tick) begin
            // Shift in from the top so the first bit on the wire lands in bit 0.
            shreg <= {i_rx, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state   <= ST_STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
            if (!rx_out.o_valid || rx_out.i_ready) begin
              rx_out.o_data      <= shreg;
              rx_out.o_frame_err <= ~i_rx;
              rx_out.o_valid     <= 1'b1;
            end else begin
              rx_out.o_overrun   <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed scoreboard bench for uart_rx_frame
module tb_uart_rx_frame;

  localparam int OSR = 16;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic rx;
  logic found;
  logic busy;

  uart_rx_frame_if #(.DATA_BITS(DB)) rx_out ();

  uart_rx_frame #(
    .OSR       (OSR),
    .DATA_BITS (DB)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_en    (en),
    .i_rx    (rx),
    .i_found (found),
    .o_busy  (busy),
    .rx_out  (rx_out)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Expected deliveries: {frame_err, data}
  logic [DB:0] sb [$];

  int lat;
  int ovr_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame with i_found at t=0 and bit centres every OSR*per clocks.
  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit brk,
                            input int per, input int fa, input int fb, input int abort_at,
                            output int lat_o, output int ovr_o);
    int   p;
    int   idx;
    logic prev_v;
    logic [DB:0] exp_e;
    p      = OSR * per;
    lat_o  = -1;
    ovr_o  = 0;
    prev_v = rx_out.o_valid;
    for (int t = 0; t < 10 * p + 4; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0;
        found = 1'b0;
        #1;
        return;
      end
      found = (t == 0) || (t == fa) || (t == fb);
      en    = ((t % per) == 0);
      idx   = (t + p / 2) / p;
      if (brk && idx <= 9) rx = 1'b0;
      else if (idx == 0)   rx = 1'b0;
      else if (idx <= 8)   rx = b[idx-1];
      else if (idx == 9)   rx = stop_v;
      else                 rx = 1'b1;
      step();
      if (t == p) chk("busy_mid_frame", 32'(busy), 32'd1);
      if (rx_out.o_valid && !prev_v) begin
        if (lat_o < 0) lat_o = t + 1;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_e = sb.pop_front();
          chk("data", 32'(rx_out.o_data), 32'(exp_e[DB-1:0]));
          chk("frame_err", 32'(rx_out.o_frame_err), 32'(exp_e[DB]));
        end
      end
      prev_v = rx_out.o_valid;
      if (rx_out.o_overrun) ovr_o++;
    end
    found = 1'b0;
    en    = 1'b1;
    rx    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    rx    = 1'b1;
    found = 1'b0;
    rx_out.i_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(rx_out.o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rx_out.o_data), 32'd0);
    chk("rst_ferr", 32'(rx_out.o_frame_err), 32'd0);
    chk("rst_overrun", 32'(rx_out.o_overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Clean 0xA5 frame
    sb.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("lat_a5", 32'(lat), 32'd145);
    chk("valid_cleared_after_accept", 32'(rx_out.o_valid), 32'd0);

    // Stop bit low, then break
    sb.push_back({1'b1, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("lat_a5_ferr", 32'(lat), 32'd145);
    sb.push_back({1'b1, 8'h00});
    send_frame(8'h00, 1'b0, 1'b1, 1, -1, -1, -1, lat, ovr_n);
    chk("lat_break", 32'(lat), 32'd145);

    // Overrun with consumer stalled
    rx_out.i_ready = 1'b0;
    sb.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("lat_3c", 32'(lat), 32'd145);
    chk("ovr_3c_none", 32'(ovr_n), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("ovr_pulse_count", 32'(ovr_n), 32'd1);
    chk("ovr_no_new_rise", 32'(lat), 32'hFFFF_FFFF);
    chk("ovr_valid_held", 32'(rx_out.o_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_out.o_data), 32'h3C);
    chk("ovr_ferr_held", 32'(rx_out.o_frame_err), 32'd0);
    rx_out.i_ready = 1'b1;
    step();
    chk("ready_clears_valid", 32'(rx_out.o_valid), 32'd0);

    // Slow enable: one tick every 4 clocks
    sb.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 1'b0, 4, -1, -1, -1, lat, ovr_n);
    chk("lat_81_slow", 32'(lat), 32'd577);

    // Mid-frame asynchronous reset with a pending byte, then a fresh frame
    rx_out.i_ready = 1'b0;
    sb.push_back({1'b0, 8'h99});
    send_frame(8'h99, 1'b1, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("pending_99_valid", 32'(rx_out.o_valid), 32'd1);
    send_frame(8'h55, 1'b1, 1'b0, 1, -1, -1, 3 * OSR + 5, lat, ovr_n);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rx_out.o_valid), 32'd0);
    chk("abort_data", 32'(rx_out.o_data), 32'd0);
    chk("abort_overrun", 32'(rx_out.o_overrun), 32'd0);
    step();
    rst_n = 1'b1;
    rx    = 1'b1;
    rx_out.i_ready = 1'b1;
    step();
    chk("post_abort_idle", 32'(busy), 32'd0);
    sb.push_back({1'b0, 8'h55});
    send_frame(8'h55, 1'b1, 1'b0, 1, -1, -1, -1, lat, ovr_n);
    chk("lat_55", 32'(lat), 32'd145);

    // Spurious i_found pulses during DATA must not restart the frame
    sb.push_back({1'b0, 8'h0F});
    send_frame(8'h0F, 1'b1, 1'b0, 1, 20, 40, -1, lat, ovr_n);
    chk("lat_0f_extra_found", 32'(lat), 32'd145);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
